// File: rtl/pe_cfg_sequencer_if.sv
// Configuration word channel into the PE configure sequencer.
// Latency: none (wires only); one word moves per cycle when cfg_valid && cfg_ready.
// Backpressure: the sequencer owns cfg_ready; the source holds its word until it is taken.
interface pe_cfg_sequencer_if #(
    parameter int PE_ID_W = 4
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [PE_ID_W-1:0] cfg_pe_id;
    logic [31:0]        cfg_word;
    logic               cfg_last;

    modport master (
        output cfg_valid,
        output cfg_pe_id,
        output cfg_word,
        output cfg_last,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_pe_id,
        input  cfg_word,
        input  cfg_last,
        output cfg_ready
    );
endinterface

// File: rtl/pe_cfg_sequencer.sv
// Loads per-PE configure words, waits SETTLE_CYC cycles, injects one head token, then waits for run_done.
// Latency: configure slice driven 1 cycle after acceptance; inject token SETTLE_CYC+1 cycles after the last word.
// Backpressure: cfg_ready high only in LOAD, one word per cycle; PE_CFG_TIMEOUT_EN adds a 16-bit RUN watchdog.
module pe_cfg_sequencer #(
    parameter int NUM_PE     = 10,
    parameter int PE_ID_W    = 4,
    parameter int MAX_WORDS  = 3,
    parameter int SETTLE_CYC = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    pe_cfg_sequencer_if.slave     cfg,
    output logic [NUM_PE*33-1:0]  pe_cfg_bus,
    output logic [35:0]           inject_data,
    input  logic                  run_done,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CNT_W  = $clog2(MAX_WORDS + 1);
    localparam int SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX     = CNT_W'(MAX_WORDS);
    // SETTLE always occupies at least one cycle, even for SETTLE_CYC of 0.
    localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [35:0]       HEAD_TOKEN  = {4'b1100, 32'd0};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        INJECT = 3'd3,
        FLUSH  = 3'd4,
        RUN    = 3'd5
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [SCNT_W-1:0]      settle_cnt;
    logic [CNT_W-1:0]       word_cnt [NUM_PE];
    logic [NUM_PE-1:0]      pe_hit;
    logic                   room_ok;
    logic                   xfer;
    logic                   legal;
    logic                   start_take;
    logic                   run_end;
    logic                   timeout;

    // Decode the addressed PE; an index beyond NUM_PE matches no slice.
    always_comb begin
        pe_hit  = '0;
        room_ok = 1'b0;
        for (int k = 0; k < NUM_PE; k++) begin
            if (cfg.cfg_pe_id == PE_ID_W'(k)) begin
                pe_hit[k] = 1'b1;
                room_ok   = (word_cnt[k] != CNT_MAX);
            end
        end
    end

    assign legal = xfer && (|pe_hit) && room_ok;

    always_comb begin
        state_d       = state_q;
        cfg.cfg_ready = 1'b0;
        start_take    = 1'b0;
        xfer          = 1'b0;
        run_end       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_take = 1'b1;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                cfg.cfg_ready = 1'b1;
                xfer          = cfg.cfg_valid;
                if (cfg.cfg_valid && cfg.cfg_last) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_d = INJECT;
                end
            end
            INJECT: state_d = FLUSH;
            FLUSH:  state_d = RUN;
            RUN: begin
                if (run_done) begin
                    run_end = 1'b1;
                    state_d = IDLE;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            settle_cnt <= '0;
        end else if (state_q == SETTLE) begin
            settle_cnt <= settle_cnt + SCNT_W'(1);
        end else begin
            settle_cnt <= '0;
        end
    end

    // Each configure slice is a one-cycle strobe; illegal words leave every slice at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pe_cfg_bus <= '0;
        end else begin
            for (int k = 0; k < NUM_PE; k++) begin
                pe_cfg_bus[k*33 +: 33] <= (legal && pe_hit[k]) ? {1'b1, cfg.cfg_word} : 33'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_PE; k++) begin
                word_cnt[k] <= '0;
            end
        end else if (start_take) begin
            for (int k = 0; k < NUM_PE; k++) begin
                word_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_PE; k++) begin
                if (legal && pe_hit[k]) begin
                    word_cnt[k] <= word_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= run_end | timeout;
            if (start_take) begin
                err <= 1'b0;
            end else if ((xfer && !legal) || timeout) begin
                err <= 1'b1;
            end
        end
    end

`ifdef PE_CFG_TIMEOUT_EN
    logic [15:0] wd_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if (state_q == RUN) begin
            wd_cnt <= wd_cnt + 16'd1;
        end else begin
            wd_cnt <= '0;
        end
    end

    // Fires on the 65535th RUN cycle, so done lands 65535 cycles after RUN entry.
    assign timeout = (state_q == RUN) && !run_done && (wd_cnt == 16'hFFFE);
`else
    assign timeout = 1'b0;
`endif

    assign busy        = (state_q != IDLE);
    assign inject_data = (state_q == INJECT) ? HEAD_TOKEN : 36'd0;

endmodule

// File: tb/tb_pe_cfg_sequencer.sv
// Self-checking bench for pe_cfg_sequencer: directed program scenarios plus randomized programs
// scored against a word-list model (per-PE quotas, expected strobe per cycle, fixed settle/inject timeline).
`timescale 1ns/1ps
module tb_pe_cfg_sequencer;
    localparam int NUM_PE     = 10;
    localparam int PE_ID_W    = 4;
    localparam int MAX_WORDS  = 3;
    localparam int SETTLE_CYC = 2;
    localparam int BUS_W      = NUM_PE * 33;
    localparam logic [35:0] INJ = 36'hC_0000_0000;

    logic              clk;
    logic              reset;
    logic              start;
    logic              run_done;
    logic [BUS_W-1:0]  pe_cfg_bus;
    logic [35:0]       inject_data;
    logic              busy;
    logic              done;
    logic              err;

    pe_cfg_sequencer_if #(.PE_ID_W(PE_ID_W)) cfg_if ();

    pe_cfg_sequencer #(
        .NUM_PE     (NUM_PE),
        .PE_ID_W    (PE_ID_W),
        .MAX_WORDS  (MAX_WORDS),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cfg         (cfg_if),
        .pe_cfg_bus  (pe_cfg_bus),
        .inject_data (inject_data),
        .run_done    (run_done),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Program to load: PE index list and payload list, last entry carries cfg_last.
    int          q_id[$];
    logic [31:0] q_word[$];
    int          cnt_model[NUM_PE];
    bit          exp_err;
    logic [BUS_W-1:0] exp_bus;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        run_done = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_pe_id = '0;
        cfg_if.cfg_word  = '0;
        cfg_if.cfg_last  = 1'b0;
        #1 reset = 1'b0;
        #2;
        compared++;
        if (pe_cfg_bus !== '0 || inject_data !== 36'd0) begin
            mismatched++;
            $display("FAIL reset_data: bus=%h inject=%h expected all zero", pe_cfg_bus, inject_data);
        end
        compared++;
        if ({busy, done, err, cfg_if.cfg_ready} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_flags: busy/done/err/ready=%b expected 0000",
                     {busy, done, err, cfg_if.cfg_ready});
        end
        step();
        step();
        reset = 1'b1;
        step();
        step();
        compared++;
        if ({busy, done, err, cfg_if.cfg_ready} !== 4'b0000 || pe_cfg_bus !== '0) begin
            mismatched++;
            $display("FAIL reset_release: busy/done/err/ready=%b bus=%h expected idle zeros",
                     {busy, done, err, cfg_if.cfg_ready}, pe_cfg_bus);
        end
    endtask

    // Starts from IDLE, plays the queued program, returns one cycle after the last handshake.
    task automatic load_program(input int gap_pct, input bit valid_with_start, input bit noise);
        int id;
        int cycles;
        start = 1'b1;
        if (valid_with_start) begin
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_pe_id = '0;
            cfg_if.cfg_word  = 32'hDEAD_BEEF;
            cfg_if.cfg_last  = 1'b1;
        end
        compared++;
        if (cfg_if.cfg_ready !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_ready: ready=%b busy=%b expected 0 0", cfg_if.cfg_ready, busy);
        end
        step();
        start = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_last  = 1'b0;
        foreach (cnt_model[k]) cnt_model[k] = 0;
        exp_err = 1'b0;
        exp_bus = '0;
        compared++;
        if (err !== 1'b0) begin
            mismatched++;
            $display("FAIL err_clear: err=%b expected 0 after start", err);
        end
        cycles = 0;
        while (q_id.size() > 0 && cycles < 500) begin
            compared++;
            if (pe_cfg_bus !== exp_bus) begin
                mismatched++;
                $display("FAIL cfg_bus: got %h expected %h", pe_cfg_bus, exp_bus);
            end
            compared++;
            if (cfg_if.cfg_ready !== 1'b1 || inject_data !== 36'd0 || busy !== 1'b1) begin
                mismatched++;
                $display("FAIL load_state: ready=%b busy=%b inject=%h expected 1 1 0",
                         cfg_if.cfg_ready, busy, inject_data);
            end
            exp_bus = '0;
            if (noise) begin
                start    = ($urandom_range(0, 9) == 0);
                run_done = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 99) >= gap_pct) begin
                id = q_id[0];
                cfg_if.cfg_valid = 1'b1;
                cfg_if.cfg_pe_id = PE_ID_W'(id);
                cfg_if.cfg_word  = q_word[0];
                cfg_if.cfg_last  = (q_id.size() == 1);
                if (cfg_if.cfg_ready === 1'b1) begin
                    if (id < NUM_PE && cnt_model[id] < MAX_WORDS) begin
                        exp_bus[id*33 +: 33] = {1'b1, q_word[0]};
                        cnt_model[id]++;
                    end else begin
                        exp_err = 1'b1;
                    end
                    void'(q_id.pop_front());
                    void'(q_word.pop_front());
                end
            end else begin
                cfg_if.cfg_valid = 1'b0;
                cfg_if.cfg_pe_id = PE_ID_W'($urandom);
                cfg_if.cfg_word  = $urandom;
                cfg_if.cfg_last  = 1'($urandom_range(0, 1));
            end
            step();
            cycles++;
        end
        start = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_last  = 1'b0;
        if (q_id.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL load_timeout: %0d words left expected 0", q_id.size());
            q_id.delete();
            q_word.delete();
        end
    endtask

    // Cycles t+1..t+5 after the last word: strobe, settle, inject at t+3, flush, RUN.
    task automatic check_tail(input bit noise);
        run_done = noise;
        for (int c = 1; c <= 5; c++) begin
            compared++;
            if (inject_data !== ((c == 3) ? INJ : 36'd0)) begin
                mismatched++;
                $display("FAIL inject_t%0d: got %h expected %h", c, inject_data, (c == 3) ? INJ : 36'd0);
            end
            compared++;
            if (pe_cfg_bus !== ((c == 1) ? exp_bus : '0)) begin
                mismatched++;
                $display("FAIL tail_bus_t%0d: got %h expected %h", c, pe_cfg_bus, (c == 1) ? exp_bus : '0);
            end
            compared++;
            if ({busy, done, cfg_if.cfg_ready, err} !== {1'b1, 1'b0, 1'b0, exp_err}) begin
                mismatched++;
                $display("FAIL tail_flags_t%0d: busy/done/ready/err=%b expected 100%b",
                         c, {busy, done, cfg_if.cfg_ready, err}, exp_err);
            end
            if (c == 5) run_done = 1'b0;
            else step();
        end
    endtask

    // Enters with the bench in the first RUN cycle; run_done arrives d cycles later.
    task automatic finish_run(input int d);
        for (int c = 0; c < d; c++) begin
            step();
            compared++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                mismatched++;
                $display("FAIL run_wait: done=%b busy=%b expected 0 1", done, busy);
            end
        end
        run_done = 1'b1;
        step();
        run_done = 1'b0;
        compared++;
        if ({done, busy, err} !== {1'b1, 1'b0, exp_err}) begin
            mismatched++;
            $display("FAIL done_pulse: done/busy/err=%b expected 10%b", {done, busy, err}, exp_err);
        end
        step();
        compared++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL done_single: done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_ten_words();
        logic [31:0] vals [10];
        vals = '{32'd2, 32'd64, 32'd32, 32'd33, 32'd128, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 10; i++) begin
            q_id.push_back(i);
            q_word.push_back(vals[i]);
        end
        load_program(0, 1'b0, 1'b0);
        check_tail(1'b0);
        finish_run(2);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) begin
            q_id.push_back(3);
            q_word.push_back($urandom);
        end
        load_program(0, 1'b0, 1'b0);
        compared++;
        if (exp_err !== 1'b1 || cnt_model[3] != MAX_WORDS) begin
            mismatched++;
            $display("FAIL overflow_model: err=%b cnt=%0d expected 1 %0d", exp_err, cnt_model[3], MAX_WORDS);
        end
        check_tail(1'b0);
        finish_run(1);
    endtask

    task automatic test_bad_id();
        q_id.push_back(12);
        q_word.push_back(32'hA5A5_5A5A);
        load_program(0, 1'b0, 1'b0);
        check_tail(1'b0);
        finish_run(0);
    endtask

    task automatic test_timing();
        q_id.push_back(7);
        q_word.push_back(32'h1234_5678);
        load_program(0, 1'b0, 1'b0);
        check_tail(1'b1);
        finish_run(5);
    endtask

    task automatic test_start_priority();
        q_id.push_back(0);
        q_word.push_back(32'h0000_0011);
        q_id.push_back(0);
        q_word.push_back(32'h0000_0022);
        q_id.push_back(0);
        q_word.push_back(32'h0000_0033);
        load_program(0, 1'b1, 1'b0);
        check_tail(1'b0);
        finish_run(1);
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 3; p++) begin
            q_id.push_back(p);
            q_word.push_back($urandom);
            q_id.push_back(p + 5);
            q_word.push_back($urandom);
            load_program(0, 1'b0, 1'b0);
            check_tail(1'b0);
            finish_run(0);
        end
    endtask

    task automatic test_reset_in_settle();
        q_id.push_back(11);
        q_word.push_back(32'hFFFF_FFFF);
        load_program(0, 1'b0, 1'b0);
        compared++;
        if (err !== 1'b1 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL settle_entry: err=%b busy=%b expected 1 1", err, busy);
        end
        #2 reset = 1'b0;
        #1;
        compared++;
        if (pe_cfg_bus !== '0 || inject_data !== 36'd0 ||
            {busy, done, err, cfg_if.cfg_ready} !== 4'b0000) begin
            mismatched++;
            $display("FAIL async_reset: bus=%h inject=%h flags=%b expected all zero",
                     pe_cfg_bus, inject_data, {busy, done, err, cfg_if.cfg_ready});
        end
        step();
        step();
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            compared++;
            if (inject_data !== 36'd0 || busy !== 1'b0 || pe_cfg_bus !== '0) begin
                mismatched++;
                $display("FAIL post_reset_c%0d: inject=%h busy=%b expected 0 0", c, inject_data, busy);
            end
        end
    endtask

    task automatic test_random();
        int n;
        for (int p = 0; p < 20; p++) begin
            n = $urandom_range(1, 14);
            for (int i = 0; i < n; i++) begin
                q_id.push_back(($urandom_range(0, 7) == 0) ? $urandom_range(NUM_PE, 15) : $urandom_range(0, NUM_PE - 1));
                q_word.push_back($urandom);
            end
            load_program(30, 1'($urandom_range(0, 1)), 1'b1);
            check_tail(1'($urandom_range(0, 1)));
            finish_run($urandom_range(0, 6));
        end
    endtask

`ifdef PE_CFG_TIMEOUT_EN
    task automatic test_watchdog();
        bit early;
        q_id.push_back(1);
        q_word.push_back(32'h0BAD_F00D);
        load_program(0, 1'b0, 1'b0);
        check_tail(1'b0);
        early = 1'b0;
        for (int c = 1; c < 65535; c++) begin
            step();
            if (done !== 1'b0) early = 1'b1;
        end
        compared++;
        if (early) begin
            mismatched++;
            $display("FAIL watchdog_early: done seen before 65535 cycles expected none");
        end
        step();
        compared++;
        if ({done, err, busy} !== 3'b110) begin
            mismatched++;
            $display("FAIL watchdog: done/err/busy=%b expected 110", {done, err, busy});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ten_words();
        test_overflow();
        test_bad_id();
        test_timing();
        test_start_priority();
        test_back_to_back();
        test_reset_in_settle();
        test_random();
`ifdef PE_CFG_TIMEOUT_EN
        test_watchdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
